// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller with per-register late-result scoreboard.
// Optional perf counters: define HAZARD_PERF_EN.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int NSRC     = 2,
    parameter int LATE_LAT = 1,
    parameter int CNT_W    = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   i_cache_stall,
    input  logic                   d_cache_stall,
    input  logic                   alu_stallE,
    input  logic                   flush_jump_conflictE,
    input  logic                   flush_pred_failedM,
    input  logic                   flush_exceptionM,
    input  logic [NSRC*REG_AW-1:0] srcD,
    input  logic [NSRC-1:0]        src_validD,
    input  logic                   regwriteE,
    input  logic                   regwriteM,
    input  logic                   regwriteW,
    input  logic [REG_AW-1:0]      writeregE,
    input  logic [REG_AW-1:0]      writeregM,
    input  logic [REG_AW-1:0]      writeregW,
    input  logic                   lateE,
    output logic [NSRC*2-1:0]      forwardD,
    output logic                   stallF,
    output logic                   stallD,
    output logic                   stallE,
    output logic                   stallM,
    output logic                   stallW,
    output logic                   flushF,
    output logic                   flushD,
    output logic                   flushE,
    output logic                   flushM,
    output logic                   flushW,
    output logic                   longest_stall,
`ifdef HAZARD_PERF_EN
    output logic                   load_use_stall,
    output logic [31:0]            perf_lu_cnt,
    output logic [31:0]            perf_cache_cnt
`else
    output logic                   load_use_stall
`endif
);

    localparam int NREG = 2 ** REG_AW;
    localparam logic [CNT_W-1:0] LATE_CNT = CNT_W'(LATE_LAT);

    logic [CNT_W-1:0] cnt [NREG];
    logic             cs;
    logic             lg;
    logic             x;
    logic             lu;
    logic             set;
    logic [REG_AW-1:0] idx;

    assign cs  = i_cache_stall | d_cache_stall;
    assign lg  = cs | alu_stallE;
    assign x   = flush_exceptionM;
    assign set = regwriteE & lateE & ~stallE & ~x & (writeregE != '0);

    always_comb begin
        forwardD = '0;
        lu       = 1'b0;
        idx      = '0;
        for (int k = 0; k < NSRC; k++) begin
            idx = srcD[k*REG_AW +: REG_AW];
            if (src_validD[k] && idx != '0) begin
                if (regwriteE && writeregE == idx)
                    forwardD[k*2 +: 2] = 2'b11;
                else if (regwriteM && writeregM == idx)
                    forwardD[k*2 +: 2] = 2'b01;
                else if (regwriteW && writeregW == idx)
                    forwardD[k*2 +: 2] = 2'b10;
                if ((regwriteE && lateE && writeregE == idx) || cnt[idx] != '0)
                    lu = 1'b1;
            end
        end
    end

    always_comb begin
        load_use_stall = lu & ~x;
        longest_stall  = lg;
        stallF         = ~x & (lg | lu);
        stallD         = lg | lu;
        stallE         = lg;
        stallM         = cs;
        stallW         = ~x & cs;
        flushF         = 1'b0;
        flushD         = x | flush_pred_failedM | (flush_jump_conflictE & ~stallD);
        flushE         = x | ((flush_pred_failedM | lu) & ~lg);
        flushM         = x;
        flushW         = x;
    end

    // A new late producer overrides any decrement; an exception clears all.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else if (x) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (set && writeregE == REG_AW'(r))
                    cnt[r] <= LATE_CNT;
                else if (!stallM && cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_lu_cnt    <= '0;
            perf_cache_cnt <= '0;
        end else begin
            if (load_use_stall) perf_lu_cnt <= perf_lu_cnt + 32'd1;
            if (cs) perf_cache_cnt <= perf_cache_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (default parameters).
// Perf counter checks run when HAZARD_PERF_EN is defined.
module tb_hazard_scoreboard;

    logic        clk;
    logic        resetn;
    logic        i_cache_stall, d_cache_stall, alu_stallE;
    logic        flush_jump_conflictE, flush_pred_failedM, flush_exceptionM;
    logic [9:0]  srcD;
    logic [1:0]  src_validD;
    logic        regwriteE, regwriteM, regwriteW;
    logic [4:0]  writeregE, writeregM, writeregW;
    logic        lateE;
    logic [3:0]  forwardD;
    logic        stallF, stallD, stallE, stallM, stallW;
    logic        flushF, flushD, flushE, flushM, flushW;
    logic        longest_stall, load_use_stall;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_cnt, perf_cache_cnt;
`endif

    int tests = 0;
    int fails = 0;

    hazard_scoreboard dut (
        .clk(clk), .resetn(resetn),
        .i_cache_stall(i_cache_stall), .d_cache_stall(d_cache_stall),
        .alu_stallE(alu_stallE),
        .flush_jump_conflictE(flush_jump_conflictE),
        .flush_pred_failedM(flush_pred_failedM),
        .flush_exceptionM(flush_exceptionM),
        .srcD(srcD), .src_validD(src_validD),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .lateE(lateE), .forwardD(forwardD),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .stallM(stallM), .stallW(stallW),
        .flushF(flushF), .flushD(flushD), .flushE(flushE),
        .flushM(flushM), .flushW(flushW),
        .longest_stall(longest_stall),
`ifdef HAZARD_PERF_EN
        .load_use_stall(load_use_stall),
        .perf_lu_cnt(perf_lu_cnt), .perf_cache_cnt(perf_cache_cnt)
`else
        .load_use_stall(load_use_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        i_cache_stall = 0; d_cache_stall = 0; alu_stallE = 0;
        flush_jump_conflictE = 0; flush_pred_failedM = 0;
        flush_exceptionM = 0;
        srcD = '0; src_validD = '0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        lateE = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] ctl();
        return {stallF, stallD, stallE, stallM, stallW, flushF,
                flushD, flushE, flushM, flushW, longest_stall,
                load_use_stall};
    endfunction

    // lw to r8 in E, op1 reads r8
    task automatic lw8_in_e();
        clr();
        regwriteE = 1; writeregE = 5'd8; lateE = 1;
        srcD = {5'd8, 5'd0}; src_validD = 2'b10;
    endtask

    initial begin
        resetn = 0;
        clr();
        #12;
        check("rst_ctl", 32'(ctl()), 32'h0);
        check("rst_fwd", 32'(forwardD), 32'h0);
        resetn = 1;
        tick();

        // forwarding priority
        regwriteE = 1; regwriteM = 1; regwriteW = 1;
        writeregE = 5; writeregM = 5; writeregW = 5;
        srcD = {5'd0, 5'd5}; src_validD = 2'b11;
        #1 check("fwd_E", 32'(forwardD), 32'h3);
        regwriteE = 0;
        #1 check("fwd_M", 32'(forwardD), 32'h1);
        regwriteM = 0;
        #1 check("fwd_W", 32'(forwardD), 32'h2);
        src_validD = 2'b10;
        #1 check("fwd_inv", 32'(forwardD), 32'h0);
        srcD = '0; src_validD = 2'b11;
        #1 check("fwd_r0", 32'(forwardD), 32'h0);
        clr();
        tick();

        // load-use, LATE_LAT=1
        lw8_in_e();
        #1;
        check("lu0_stall", 32'(load_use_stall), 32'h1);
        check("lu0_sFD", 32'({stallF, stallD, stallE}), 32'h6);
        check("lu0_flushE", 32'(flushE), 32'h1);
        tick();
        regwriteE = 0; lateE = 0; regwriteM = 1; writeregM = 8;
        #1;
        check("lu1_stall", 32'(load_use_stall), 32'h1);
        check("lu1_stallD", 32'(stallD), 32'h1);
        tick();
        regwriteM = 0; regwriteW = 1; writeregW = 8;
        #1;
        check("lu2_stall", 32'(load_use_stall), 32'h0);
        check("lu2_stallD", 32'(stallD), 32'h0);
        check("lu2_fwd", 32'(forwardD), 32'h8);
        clr();
        tick();

        // cache stall holds a pending entry
        lw8_in_e();
        tick();
        regwriteE = 0; lateE = 0; d_cache_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("cs_lu", 32'(load_use_stall), 32'h1);
            check("cs_stallM", 32'(stallM), 32'h1);
            check("cs_flushE", 32'(flushE), 32'h0);
            tick();
        end
        d_cache_stall = 0;
        #1 check("cs_rel_lu", 32'(load_use_stall), 32'h1);
        tick();
        check("cs_clear", 32'(load_use_stall), 32'h0);
        clr();
        tick();

        // exception clears a held entry
        lw8_in_e();
        tick();
        regwriteE = 0; lateE = 0; d_cache_stall = 1; flush_exceptionM = 1;
        #1;
        check("x_flushDEMW", 32'({flushD, flushE, flushM, flushW}), 32'hf);
        check("x_stallFW", 32'({stallF, stallW}), 32'h0);
        check("x_lu", 32'(load_use_stall), 32'h0);
        tick();
        d_cache_stall = 0; flush_exceptionM = 0;
        #1 check("x_cleared", 32'(load_use_stall), 32'h0);

        // exception wins over a new set
        clr();
        regwriteE = 1; writeregE = 9; lateE = 1; flush_exceptionM = 1;
        srcD = {5'd9, 5'd0}; src_validD = 2'b10;
        #1 check("x_set_lu", 32'(load_use_stall), 32'h0);
        tick();
        clr();
        srcD = {5'd9, 5'd0}; src_validD = 2'b10;
        #1 check("x_noset", 32'(load_use_stall), 32'h0);
        clr();
        tick();

        // jump conflict vs stalls
        flush_jump_conflictE = 1; alu_stallE = 1;
        #1 check("jmp_alu", 32'(flushD), 32'h0);
        alu_stallE = 0;
        regwriteE = 1; writeregE = 3; lateE = 1;
        srcD = {5'd0, 5'd3}; src_validD = 2'b01;
        #1 check("jmp_lu", 32'(flushD), 32'h0);
        regwriteE = 0; lateE = 0; src_validD = 2'b00;
        #1 check("jmp_free", 32'(flushD), 32'h1);
        clr();
        tick();

`ifdef HAZARD_PERF_EN
        resetn = 0;
        #1;
        check("perf_rst_lu", perf_lu_cnt, 32'd0);
        resetn = 1;
        tick();
        regwriteE = 1; writeregE = 12; lateE = 1;
        srcD = {5'd0, 5'd12}; src_validD = 2'b01;
        for (int i = 0; i < 4; i++) tick();
        clr();
        d_cache_stall = 1;
        for (int i = 0; i < 7; i++) tick();
        clr();
        tick();
        check("perf_lu", perf_lu_cnt, 32'd4);
        check("perf_cache", perf_cache_cnt, 32'd7);
        resetn = 0;
        #1;
        check("perf_lu_rst", perf_lu_cnt, 32'd0);
        check("perf_cache_rst", perf_cache_cnt, 32'd0);
        resetn = 1;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
